share_recombiner: RTL and testbench

SHARE_RECOMBINER -- requirements
Module: share_recombiner

---
 rtl/share_recombiner.sv | 66 ++++++
 tb/tb_share_recombiner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/share_recombiner.sv
// Serially XORs NUM_SHARES masked shares into one unmasked value; the result is valid the cycle after the last share is accepted.
// Backpressure: in_ready = !out_valid || out_ready. A group of the wrong length is dropped and flagged with a one-cycle err_len pulse.
module share_recombiner #(
    parameter int DATA_W     = 8,
    parameter int NUM_SHARES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_share,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_len
);

    localparam int CNT_W = $clog2(NUM_SHARES);

    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last_slot;
    logic              complete;
    logic              bad_len;
    logic              advance;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_slot = (cnt == CNT_W'(NUM_SHARES - 1));
    assign complete  = accept && last_slot && in_last;
    // Early last and missing last both show up as in_last disagreeing with the slot position.
    assign bad_len   = accept && (last_slot != in_last);
    assign advance   = accept && !last_slot && !in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            err_len <= bad_len;

            if (complete) begin
                out_data  <= acc ^ in_share;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                // Clear the unmasked value as soon as the consumer has taken it.
                out_data  <= '0;
                out_valid <= 1'b0;
            end

            if (complete || bad_len) begin
                acc <= '0;
                cnt <= '0;
            end else if (advance) begin
                acc <= acc ^ in_share;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_share_recombiner.sv
// Directed bench for share_recombiner (DATA_W=8, NUM_SHARES=3) with hand-computed results.
module tb_share_recombiner;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_share;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err_len;

    int total = 0;
    int bad   = 0;

    share_recombiner #(.DATA_W(8), .NUM_SHARES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_share  (in_share),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Offer one share across one clock edge; in_ready is checked before the edge.
    task automatic beat(input logic [7:0] s, input logic l, input logic exp_rdy);
        in_share = s;
        in_last  = l;
        in_valid = 1'b1;
        #1;
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_share = 8'h00;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] d);
        chk({tag, "_valid"}, out_valid, v);
        chk({tag, "_data"}, out_data, d);
    endtask

    initial begin
        // Reset with inputs active: nothing may leak through.
        rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_share = 8'hA5; out_ready = 1'b0;
        idle(); idle();
        expect_out("rst", 1'b0, 8'h00);
        chk("rst_err", err_len, 1'b0);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_share = 8'h00; out_ready = 1'b1;
        #1;
        chk("rdy_after_rst", in_ready, 1'b1);
        idle();

        // Basic group
        beat(8'h5A, 1'b0, 1'b1);
        beat(8'h3C, 1'b0, 1'b1);
        expect_out("basic_mid", 1'b0, 8'h00);
        beat(8'h0F, 1'b1, 1'b1);
        expect_out("basic", 1'b1, 8'h69);
        idle();
        expect_out("basic_pop", 1'b0, 8'h00);

        // Back-to-back groups, in_ready must stay high every beat
        beat(8'hFF, 1'b0, 1'b1);
        beat(8'h00, 1'b0, 1'b1);
        beat(8'h01, 1'b1, 1'b1);
        expect_out("b2b_a", 1'b1, 8'hFE);
        beat(8'h12, 1'b0, 1'b1);
        expect_out("b2b_a_pop", 1'b0, 8'h00);
        beat(8'h34, 1'b0, 1'b1);
        beat(8'h56, 1'b1, 1'b1);
        expect_out("b2b_b", 1'b1, 8'h70);
        idle();
        expect_out("b2b_b_pop", 1'b0, 8'h00);

        // Backpressure: result held, extra share refused
        out_ready = 1'b0;
        beat(8'hAA, 1'b0, 1'b1);
        beat(8'h55, 1'b0, 1'b1);
        beat(8'h00, 1'b1, 1'b1);
        expect_out("bp", 1'b1, 8'hFF);
        in_share = 8'h77; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_rdy", in_ready, 1'b0);
            idle();
            expect_out("bp_hold", 1'b1, 8'hFF);
        end
        in_valid = 1'b0; in_share = 8'h00; out_ready = 1'b1;
        idle();
        expect_out("bp_pop", 1'b0, 8'h00);

        // Early last
        beat(8'h11, 1'b0, 1'b1);
        beat(8'h22, 1'b1, 1'b1);
        chk("early_err", err_len, 1'b1);
        expect_out("early", 1'b0, 8'h00);
        idle();
        chk("early_err_end", err_len, 1'b0);
        chk("early_no_out", out_valid, 1'b0);
        beat(8'h01, 1'b0, 1'b1);
        beat(8'h02, 1'b0, 1'b1);
        beat(8'h04, 1'b1, 1'b1);
        expect_out("after_early", 1'b1, 8'h07);
        idle();

        // Missing last
        beat(8'h10, 1'b0, 1'b1);
        beat(8'h20, 1'b0, 1'b1);
        beat(8'h40, 1'b0, 1'b1);
        chk("miss_err", err_len, 1'b1);
        expect_out("miss", 1'b0, 8'h00);
        idle();
        chk("miss_err_end", err_len, 1'b0);
        beat(8'h01, 1'b0, 1'b1);
        beat(8'h01, 1'b0, 1'b1);
        beat(8'h03, 1'b1, 1'b1);
        expect_out("after_miss", 1'b1, 8'h03);
        idle();

        // Reset mid-group
        beat(8'h33, 1'b0, 1'b1);
        rst = 1'b1;
        idle();
        expect_out("midrst", 1'b0, 8'h00);
        chk("midrst_err", err_len, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_rdy", in_ready, 1'b1);
        idle();
        chk("midrst_err_after", err_len, 1'b0);
        beat(8'h0F, 1'b0, 1'b1);
        beat(8'hF0, 1'b0, 1'b1);
        beat(8'h00, 1'b1, 1'b1);
        expect_out("after_rst", 1'b1, 8'hFF);
        chk("after_rst_err", err_len, 1'b0);
        idle();
        expect_out("after_rst_pop", 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
